// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/DIV engine that owns the HI/LO registers
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,       // pipeline clock
    input  logic             rst_n,     // asynchronous active-low reset
    input  logic             i_valid,   // HI/LO-class instruction present in EX
    input  logic [5:0]       i_fun,     // funct field selecting the operation
    input  logic [WIDTH-1:0] i_a,       // rs operand
    input  logic [WIDTH-1:0] i_b,       // rt operand
    input  logic             i_cancel,  // flush of the in-flight operation
    output logic             o_stall,   // hold ID/EX and upstream stages
    output logic             o_busy,    // multi-cycle operation in progress
    output logic [WIDTH-1:0] o_rdata,   // MFHI/MFLO read data
    output logic [WIDTH-1:0] o_hi,      // architectural HI
    output logic [WIDTH-1:0] o_lo,      // architectural LO
    output logic             o_done     // pulse when HI/LO take a mult/div result
);

    localparam logic [5:0] FUN_MFHI  = 6'h10;
    localparam logic [5:0] FUN_MTHI  = 6'h11;
    localparam logic [5:0] FUN_MFLO  = 6'h12;
    localparam logic [5:0] FUN_MTLO  = 6'h13;
    localparam logic [5:0] FUN_MULT  = 6'h18;
    localparam logic [5:0] FUN_MULTU = 6'h19;
    localparam logic [5:0] FUN_DIV   = 6'h1A;
    localparam logic [5:0] FUN_DIVU  = 6'h1B;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // acc holds {high, low} of the product, or {remainder, quotient} for divide.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   raw_a_q;     // unmodified dividend for divide-by-zero
    logic [CW-1:0]      cnt_q;
    logic               neg_res_q;   // product sign, or quotient sign
    logic               neg_rem_q;   // remainder follows the dividend sign
    logic               div_zero_q;
    logic               op_div_q;
    logic               done_q;

    logic is_mult, is_multu, is_div, is_divu;
    logic is_mfhi, is_mflo, is_mthi, is_mtlo, is_hilo;
    logic start_mul, start_div, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_mult  = (i_fun == FUN_MULT);
    assign is_multu = (i_fun == FUN_MULTU);
    assign is_div   = (i_fun == FUN_DIV);
    assign is_divu  = (i_fun == FUN_DIVU);
    assign is_mfhi  = (i_fun == FUN_MFHI);
    assign is_mflo  = (i_fun == FUN_MFLO);
    assign is_mthi  = (i_fun == FUN_MTHI);
    assign is_mtlo  = (i_fun == FUN_MTLO);
    assign is_hilo  = is_mult | is_multu | is_div | is_divu |
                      is_mfhi | is_mflo | is_mthi | is_mtlo;

    assign start_mul = i_valid & (is_mult | is_multu);
    assign start_div = i_valid & (is_div | is_divu);

    // Unsigned variants take the raw operands; signed variants work on magnitudes.
    assign signed_op = is_mult | is_div;
    assign a_neg     = signed_op & i_a[WIDTH-1];
    assign b_neg     = signed_op & i_b[WIDTH-1];
    assign a_mag     = a_neg ? (~i_a + 1'b1) : i_a;
    assign b_mag     = b_neg ? (~i_b + 1'b1) : i_b;

    // Shift-add step: add multiplicand into the high half when the multiplier
    // LSB is set, then shift the whole accumulator right by one.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder and keep
    // the subtraction only when it does not borrow.
    logic [WIDTH:0]       div_shift, div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   div_step;
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_step  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ok};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (op_div_q) begin
            if (div_zero_q) begin
                fix_hi = raw_a_q;
                fix_lo = '1;
            end else begin
                fix_lo = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
                fix_hi = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                                   : acc_q[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_busy  = (state_q != S_IDLE);
        o_stall = i_valid & (state_q != S_IDLE) & is_hilo;
        o_rdata = '0;
        if (!o_stall) begin
            if (is_mfhi) begin
                o_rdata = o_hi;
            end else if (is_mflo) begin
                o_rdata = o_lo;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (!i_cancel) begin
                    if (start_mul) begin
                        state_d = S_MUL;
                    end else if (start_div) begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (i_cancel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hi       <= '0;
            o_lo       <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            raw_a_q    <= '0;
            cnt_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            op_div_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (i_valid && !i_cancel) begin
                        if (start_mul || start_div) begin
                            acc_q      <= {{WIDTH{1'b0}}, a_mag};
                            opnd_q     <= b_mag;
                            raw_a_q    <= i_a;
                            neg_res_q  <= a_neg ^ b_neg;
                            neg_rem_q  <= a_neg;
                            op_div_q   <= start_div;
                            div_zero_q <= start_div & (i_b == '0);
                        end else if (is_mthi) begin
                            o_hi <= i_a;
                        end else if (is_mtlo) begin
                            o_lo <= i_a;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_DIV: begin
                    acc_q <= div_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIX: begin
                    if (!i_cancel) begin
                        o_hi   <= fix_hi;
                        o_lo   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign o_done = done_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic [5:0]    i_fun;
    logic [W-1:0]  i_a, i_b;
    logic          i_cancel;
    logic          o_stall, o_busy, o_done;
    logic [W-1:0]  o_rdata, o_hi, o_lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_fun    (i_fun),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_cancel (i_cancel),
        .o_stall  (o_stall),
        .o_busy   (o_busy),
        .o_rdata  (o_rdata),
        .o_hi     (o_hi),
        .o_lo     (o_lo),
        .o_done   (o_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_op(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (f)
            6'h18: r = 64'(sa * sb);
            6'h19: r = {32'b0, a} * {32'b0, b};
            6'h1A: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            6'h1B: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic bit is_start(input logic [5:0] f);
        return (f >= 6'h18) && (f <= 6'h1B);
    endfunction

    function automatic bit is_hilo(input logic [5:0] f);
        return is_start(f) || ((f >= 6'h10) && (f <= 6'h13));
    endfunction

    // Transaction-level model: a started op is pending for WIDTH+1 cycles,
    // then its arithmetic result lands in HI/LO.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_rem;
    logic        m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_res  <= '0;
            m_rem  <= 0;
            m_done <= 1'b0;
        end else if (m_rem > 0) begin
            if (i_cancel) begin
                m_rem  <= 0;
                m_done <= 1'b0;
            end else if (m_rem == 1) begin
                m_hi   <= m_res[63:32];
                m_lo   <= m_res[31:0];
                m_rem  <= 0;
                m_done <= 1'b1;
            end else begin
                m_rem  <= m_rem - 1;
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (i_valid && !i_cancel) begin
                if (is_start(i_fun)) begin
                    m_res <= model_op(i_fun, i_a, i_b);
                    m_rem <= W + 1;
                end else if (i_fun == 6'h11) begin
                    m_hi <= i_a;
                end else if (i_fun == 6'h13) begin
                    m_lo <= i_a;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_stall;
        logic [31:0] exp_rdata;
        if (rst_n) begin
            exp_stall = i_valid && (m_rem > 0) && is_hilo(i_fun);
            check("busy", {31'b0, o_busy}, {31'b0, (m_rem > 0)});
            check("done", {31'b0, o_done}, {31'b0, m_done});
            check("hi", o_hi, m_hi);
            check("lo", o_lo, m_lo);
            check("stall", {31'b0, o_stall}, {31'b0, exp_stall});
            if (!exp_stall) begin
                exp_rdata = (i_fun == 6'h10) ? m_hi : (i_fun == 6'h12) ? m_lo : 32'h0;
                check("rdata", o_rdata, exp_rdata);
            end
        end
    end

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ex_hi, input logic [31:0] ex_lo,
                          input string name);
        int lat;
        lat = -1;
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_fun   = f;
        i_a     = a;
        i_b     = b;
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            @(negedge clk);
            if (o_done && lat < 0) lat = k;
        end
        check({name, " latency"}, lat, 34);
        check({name, " hi"}, o_hi, ex_hi);
        check({name, " lo"}, o_lo, ex_lo);
    endtask

    initial begin
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_fun    = 6'h0;
        i_a      = '0;
        i_b      = '0;
        i_cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, o_busy}, 32'h0);
        check("reset done", {31'b0, o_done}, 32'h0);
        check("reset hi", o_hi, 32'h0);
        check("reset lo", o_lo, 32'h0);
        rst_n = 1'b1;

        run_op(6'h18, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");

        // MULTU then an MFHI held by the hazard unit from T+5.
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_fun   = 6'h19;
        i_a     = 32'hFFFF_FFFF;
        i_b     = 32'hFFFF_FFFF;
        @(negedge clk);
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) i_valid = 1'b0;
            if (k == 5) begin
                i_valid = 1'b1;
                i_fun   = 6'h10;
            end
            if (k == 35) i_valid = 1'b0;
            @(negedge clk);
            if (k >= 5 && k <= 34) check("mfhi stall", {31'b0, o_stall}, {31'b0, (k <= 33)});
            if (k == 34) check("mfhi rdata", o_rdata, 32'hFFFF_FFFE);
        end
        check("multu lo", o_lo, 32'h0000_0001);

        run_op(6'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div neg");
        run_op(6'h1B, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu");
        run_op(6'h1A, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, "div zero");
        run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div ovf");

        // MTHI in idle.
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_fun   = 6'h11;
        i_a     = 32'hCAFE_BABE;
        @(negedge clk);
        check("mthi stall", {31'b0, o_stall}, 32'h0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("mthi hi", o_hi, 32'hCAFE_BABE);

        // MULT cancelled at T+10; an unrelated funct while busy must not stall.
        begin
            bit seen_done;
            seen_done = 1'b0;
            @(posedge clk);
            #1;
            i_valid = 1'b1;
            i_fun   = 6'h18;
            i_a     = 32'h0000_1234;
            i_b     = 32'h0000_0010;
            @(negedge clk);
            for (int k = 1; k <= 40; k++) begin
                @(posedge clk);
                #1;
                if (k == 1) i_valid = 1'b0;
                if (k == 3) begin
                    i_valid = 1'b1;
                    i_fun   = 6'h20;
                end
                if (k == 4) i_valid = 1'b0;
                if (k == 10) i_cancel = 1'b1;
                if (k == 11) i_cancel = 1'b0;
                @(negedge clk);
                if (o_done) seen_done = 1'b1;
                if (k == 3) check("other funct stall", {31'b0, o_stall}, 32'h0);
                if (k == 11) check("cancel busy", {31'b0, o_busy}, 32'h0);
            end
            check("cancel done", {31'b0, seen_done}, 32'h0);
            check("cancel hi", o_hi, 32'hCAFE_BABE);
            check("cancel lo", o_lo, 32'h8000_0000);
        end

        // Asynchronous reset in the middle of a DIV.
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_fun   = 6'h1A;
        i_a     = 32'd100;
        i_b     = 32'd7;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            i_valid = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst busy", {31'b0, o_busy}, 32'h0);
        check("async rst hi", o_hi, 32'h0);
        check("async rst lo", o_lo, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op(6'h19, 32'd3, 32'd5, 32'h0, 32'd15, "multu after rst");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
